// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/arb_wait_counter.sv
// Loadable down-counter with a zero flag; stops at zero.
module arb_wait_counter #(
  parameter int CNT_W = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] loadValue,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             isZero
);

  // Load takes priority over decrement; never wraps below zero.
  always_ff @(posedge Clock) begin
    // NOTE: non-blocking so every flop samples pre-edge values.
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign isZero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and
// load/store, holding each access for MEM_LAT cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic [DATA_W-1:0] IData,
  output logic              IValid,
  input  logic              DReq,
  input  logic              DWrite,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWData,
  output logic [DATA_W-1:0] DRData,
  output logic              DValid,
  output logic              Stall,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] MemRData
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  arb_state_t       state;
  arb_state_t       stateNext;
  arb_owner_t       owner;
  logic [ADDR_W-1:0] latAddr;
  logic [DATA_W-1:0] latWData;
  logic             latWrite;
  logic [STV_W-1:0] starveCnt;
  logic [CNT_W-1:0] waitCount;
  logic             waitZero;

  logic grantD;
  logic grantI;
  logic lastCycle;
  logic isRead;

  // Data side wins unless fetch has been passed over STARVE_MAX times in a row.
  assign grantD    = (state == IDLE) && DReq &&
                     (!IReq || (starveCnt < STV_W'(STARVE_MAX)));
  assign grantI    = (state == IDLE) && !grantD && IReq;
  assign lastCycle = (state == ACCESS) && (waitCount == CNT_W'(1));
  assign isRead    = (owner == OWN_I) || !latWrite;

  arb_wait_counter #(
    .CNT_W(CNT_W)
  ) u_wait (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (grantD || grantI),
    .loadValue(CNT_W'(MEM_LAT)),
    .dec      ((state == ACCESS) && !waitZero),
    .count    (waitCount),
    .isZero   (waitZero)
  );

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state and strobe/valid decode.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    stateNext = state;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IValid    = 1'b0;
    DValid    = 1'b0;
    unique case (state)
      IDLE:   if (grantD || grantI) stateNext = ACCESS;
      ACCESS: begin
        MemRead  = isRead;
        MemWrite = (owner == OWN_D) && latWrite;
        if (lastCycle) stateNext = DONE;
      end
      DONE: begin
        IValid    = (owner == OWN_I);
        DValid    = (owner == OWN_D);
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Capture owner and request fields at grant; held through the access.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      owner    <= OWN_I;
      latAddr  <= '0;
      latWData <= '0;
      latWrite <= 1'b0;
    end else if (grantD) begin
      owner    <= OWN_D;
      latAddr  <= DAddr;
      latWData <= DWData;
      latWrite <= DWrite;
    end else if (grantI) begin
      owner    <= OWN_I;
      latAddr  <= IAddr;
      latWrite <= 1'b0;
    end
  end

  // Read data is sampled on the last access edge; stores leave DRData alone.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      IData  <= '0;
      DRData <= '0;
    end else if (lastCycle && isRead) begin
      if (owner == OWN_I) IData  <= MemRData;
      else                DRData <= MemRData;
    end
  end

  // Count consecutive data grants that bypassed a waiting fetch.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      starveCnt <= '0;
    end else if (grantI) begin
      starveCnt <= '0;
    end else if (grantD && IReq && (starveCnt != STV_W'(STARVE_MAX))) begin
      starveCnt <= starveCnt + STV_W'(1);
    end
  end

  assign MemAddr  = latAddr;
  assign MemWData = latWData;
  assign Stall    = (IReq && !IValid) || (DReq && !DValid);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-ported memory between the IF stage (instruction fetch) and the MEM stage (load/store).
- Holds each access for a parameterised number of wait cycles and returns data with a one-cycle valid pulse.
- Drives a pipeline stall while any requester is waiting.
- Sits between the processor top level and the external memory; replaces the separate InstrMem/MemData ports with a single port.

Parameters:
- ADDR_W, 16, address width of all address ports.
- DATA_W, 32, data width of all data ports.
- MEM_LAT, 2, cycles each memory strobe is held before read data is sampled; legal range 1..15.
- STARVE_MAX, 3, maximum consecutive data grants while IReq is pending before fetch is forced.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- IReq  in  1  fetch request; level, held until IValid.
- IAddr  in  ADDR_W  fetch address.
- IData  out  DATA_W  fetched instruction; valid when IValid=1.
- IValid  out  1  one-cycle fetch-complete pulse.
- DReq  in  1  data request; level, held until DValid.
- DWrite  in  1  1=store, 0=load; sampled with DReq at grant.
- DAddr  in  ADDR_W  data address.
- DWData  in  DATA_W  store data.
- DRData  out  DATA_W  load data; valid when DValid=1.
- DValid  out  1  one-cycle data-complete pulse (loads and stores).
- Stall  out  1  (IReq & ~IValid) | (DReq & ~DValid); combinational.
- MemAddr  out  ADDR_W  memory address.
- MemWData  out  DATA_W  memory write data.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- MemRData  in  DATA_W  memory read data.

Behaviour:
- Reset:
  - State IDLE; wait counter 0; starvation counter 0.
  - All outputs except Stall are 0. This includes IData, DRData, MemAddr and MemWData.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, arbitration in cycle N:
  - If DReq=1 and (IReq=0 or starve count < STARVE_MAX): grant D.
  - Else if IReq=1: grant I.
  - Else stay IDLE.
- On grant:
  - Latch owner, address, DWrite and DWData at edge N; go to ACCESS; load the wait counter with MEM_LAT.
  - Starvation counter: +1 on a D grant while IReq=1 (saturating at STARVE_MAX); cleared on any I grant.
- ACCESS, cycles N+1 .. N+MEM_LAT:
  - MemAddr and MemWData come from the latched values.
  - MemRead = owner is I, or owner is D with DWrite=0. MemWrite = owner is D with DWrite=1.
  - The counter decrements each cycle. At the edge where counter==1: register MemRData into IData/DRData (reads only), deassert strobes, go to DONE.
- DONE, cycle N+MEM_LAT+1:
  - The owner's Valid = 1 for exactly this cycle; no arbitration.
  - Next state IDLE. The requester updates or drops its Req at this edge.
- Timing:
  - Request-to-Valid latency is MEM_LAT+1 cycles.
  - Throughput is one access per MEM_LAT+2 cycles.
- IData/DRData hold their last value until the next read completion of the same owner. Stores leave DRData unchanged.
- Latched address and data are immune to input changes during ACCESS.
- Req dropped mid-access: the access completes and Valid still pulses. The requester ignores it.
- Simultaneous IReq and DReq from IDLE: D wins unless the starvation counter equals STARVE_MAX.
- MEM_LAT=1: ACCESS lasts one cycle; the strobe is a single-cycle pulse.
- Reset asserted mid-ACCESS or in DONE: strobes and Valid are 0 from the next cycle. A pending write may have been partially presented; no retry.
- Stall is combinational on Req/Valid. It is 0 in the DONE cycle for the completing owner.

Decomposition:
- Package mem_arb_pkg holds:
  - enum arb_state_t {IDLE, ACCESS, DONE}
  - enum arb_owner_t {OWN_I, OWN_D}
  - default width constants ADDR_W_DEF=16 and DATA_W_DEF=32
- Sub-module arb_wait_counter: loadable down-counter with a zero flag, parameterised by MEM_LAT width. It is reused later for multi-cycle MUL sequencing.
- The FSM, starvation logic and datapath latches stay in mem_port_arbiter.

Test Plan:
- Reset, then single fetch: IReq=1, IAddr=16'h0040, MemRData=32'h2008_0005, MEM_LAT=2.
  - MemRead=1 for cycles 1–2 with MemAddr=16'h0040.
  - IValid=1 in cycle 3 with IData=32'h2008_0005.
  - Stall=1 in cycles 0–2.
- Load/store: DReq=1, DWrite=1, DAddr=16'h0100, DWData=32'hDEAD_BEEF.
  - MemWrite=1 for 2 cycles with MemWData=32'hDEAD_BEEF.
  - DValid pulse; DRData unchanged.
  - A following load from 16'h0100 with MemRData=32'hDEAD_BEEF gives DRData=32'hDEAD_BEEF.
- Contention: IReq and DReq both held, D re-requests immediately after each DValid.
  - Grants are D,D,D,I,D,D,D,I (STARVE_MAX=3).
  - No cycle has both MemRead and MemWrite.
- Input change mid-access: DAddr changes from 16'h0200 to 16'h0300 in cycle 2.
  - MemAddr stays 16'h0200 for the whole access.
- Reset mid-ACCESS (cycle 1 of a write), then Reset deasserted.
  - MemWrite=0 and DValid=0 the next cycle; state is IDLE.
  - A new IReq is granted normally with full latency.
- MEM_LAT=1 build with back-to-back fetches.
  - IValid pulses every 3 cycles.
  - MemRead is a 1-cycle pulse per access.
